aes_round_key_sequencer: RTL and testbench

- Controller that sequences the AES key expander across a full encryption: enables it, steps key_sel through rounds 0..NUM_ROUNDS, and captures each round_key when key_rdy is high.
- Presents each captured key to the cipher round datapath over a valid/ready handshake.
- Sits between the key expander and the round datapath inside the encryption core. Owns round ordering, back-pressure, a key_rdy timeout, and abort.

---
 rtl/aes_round_key_sequencer_if.sv | 43 ++++
 rtl/aes_round_key_sequencer.sv | 134 +++++++++++++
 tb/tb_aes_round_key_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_key_sequencer_if.sv
// ---------------------------------------------------------------------------
// aes_round_key_sequencer_if
// Bundles the control, key-expander and round-datapath signals of the
// round key sequencer.
//   master : the sequencer (drives encrypt_en/key_sel, rk_* outputs, status)
//   slave  : the surrounding core (drives start/abort, key_rdy/round_key,
//            rk_ready)
// Signals:
//   start, abort          control requests into the sequencer
//   encrypt_en, key_sel   request to the key expander
//   key_rdy, round_key    response from the key expander (16 bytes)
//   rk_valid/rk_ready     handshake to the round datapath
//   rk_data/rk_round/rk_last  payload of that handshake
//   busy, done, timeout_err   status
// ---------------------------------------------------------------------------
interface aes_round_key_sequencer_if;
  logic                  start;
  logic                  abort;
  logic                  encrypt_en;
  logic [3:0]            key_sel;
  logic                  key_rdy;
  logic [3:0][3:0][7:0]  round_key;
  logic                  rk_valid;
  logic                  rk_ready;
  logic [3:0][3:0][7:0]  rk_data;
  logic [3:0]            rk_round;
  logic                  rk_last;
  logic                  busy;
  logic                  done;
  logic                  timeout_err;

  modport master (
    input  start, abort, key_rdy, round_key, rk_ready,
    output encrypt_en, key_sel, rk_valid, rk_data, rk_round, rk_last,
           busy, done, timeout_err
  );

  modport slave (
    output start, abort, key_rdy, round_key, rk_ready,
    input  encrypt_en, key_sel, rk_valid, rk_data, rk_round, rk_last,
           busy, done, timeout_err
  );
endinterface

// File: rtl/aes_round_key_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_key_sequencer
// Walks the AES key expander through rounds 0..NUM_ROUNDS, captures each
// round key when key_rdy is seen and hands it to the round datapath over a
// valid/ready handshake. Handles back-pressure, a key_rdy timeout and abort.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    aes_round_key_sequencer_if.master (see interface header)
// All outputs are decoded from registered state, so there is no
// combinational path from any input to any output.
// ---------------------------------------------------------------------------
module aes_round_key_sequencer #(
  parameter int NUM_ROUNDS     = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  aes_round_key_sequencer_if.master   bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam int          TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  LAST_RND = 4'(NUM_ROUNDS);

  logic [1:0]           state_q, state_d;
  logic [3:0]           round_q, round_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 err_q, err_d;
  logic                 cap;
  logic [3:0][3:0][7:0] rk_data_q;
  logic [3:0]           rk_round_q;
  logic                 rk_last_q;

  // Next-state logic. abort outranks every other event in a busy state,
  // including a key capture or a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    cap     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = S_REQ;
          round_d = 4'd0;
          tmo_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_REQ: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.key_rdy) begin
          cap     = 1'b1;
          state_d = S_PRESENT;
          tmo_d   = '0;
        end else if (tmo_q == TMO_MAX) begin
          // tmo_q counts REQ cycles already spent, so this is the last one
          err_d   = 1'b1;
          state_d = S_IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d   = tmo_q + 1'b1;
        end
      end
      S_PRESENT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.rk_ready) begin
          if (round_q == LAST_RND) begin
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
            round_d = round_q + 4'd1;
            tmo_d   = '0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      round_q <= 4'd0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Payload registers only load on a capture in REQ, so they keep the last
  // key across PRESENT back-pressure, abort and timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rk_data_q  <= '0;
      rk_round_q <= 4'd0;
      rk_last_q  <= 1'b0;
    end else if (cap) begin
      rk_data_q  <= bus.round_key;
      rk_round_q <= round_q;
      rk_last_q  <= (round_q == LAST_RND);
    end
  end

  logic en;
  assign en = (state_q == S_REQ) || (state_q == S_PRESENT);

  assign bus.encrypt_en  = en;
  assign bus.key_sel     = en ? round_q : 4'd0;
  assign bus.rk_valid    = (state_q == S_PRESENT);
  assign bus.rk_data     = rk_data_q;
  assign bus.rk_round    = rk_round_q;
  assign bus.rk_last     = rk_last_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_aes_round_key_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_round_key_sequencer
// Directed stimulus drives the key expander / datapath side; each key handed
// to the sequencer is pushed into a scoreboard queue and a negedge monitor
// compares every presented rk_* word against the queue head.
// ---------------------------------------------------------------------------
module tb_aes_round_key_sequencer;
  localparam int NR = 10;
  localparam int TO = 64;

  typedef logic [3:0][3:0][7:0] key_t;
  typedef struct packed {
    logic [3:0] rnd;
    logic       last;
    key_t       data;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aes_round_key_sequencer_if bus();

  aes_round_key_sequencer #(.NUM_ROUNDS(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sbq[$];
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   done_at  = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic key_t key_of(int r, logic [7:0] salt);
    key_t k;
    for (int i = 0; i < 16; i++) k[i/4][i%4] = 8'(r * 16 + i) ^ salt;
    return k;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard on every valid cycle (covers stability under stall)
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.done) begin
        done_cnt++;
        done_at = cyc;
      end
      if (bus.rk_valid) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_empty: rk_valid round %0d but nothing expected", bus.rk_round);
        end else begin
          chk("sb_data", bus.rk_data, sbq[0].data);
          chk("sb_round", 128'(bus.rk_round), 128'(sbq[0].rnd));
          chk("sb_last", 128'(bus.rk_last), 128'(sbq[0].last));
          if (bus.rk_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_seq();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Wait until the sequencer is in REQ for round r
  task automatic wait_req(int r);
    int n = 0;
    while (!(bus.encrypt_en && !bus.rk_valid && bus.key_sel == 4'(r))) begin
      tick();
      n++;
      if (n > 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL wait_req: round %0d never requested, key_sel=%0d", r, bus.key_sel);
        return;
      end
    end
  endtask

  task automatic give_key(int r, logic [7:0] salt);
    exp_t e;
    e.rnd  = 4'(r);
    e.last = (r == NR);
    e.data = key_of(r, salt);
    sbq.push_back(e);
    bus.round_key = key_of(r, salt);
    bus.key_rdy   = 1'b1;
    tick();
    bus.key_rdy   = 1'b0;
  endtask

  task automatic run_round(int r, int dly, logic [7:0] salt);
    wait_req(r);
    for (int i = 0; i < dly; i++) begin
      chk("key_sel_req", 128'(bus.key_sel), 128'(r));
      tick();
    end
    give_key(r, salt);
  endtask

  task automatic run_seq(int first, int last, int dly, logic [7:0] salt);
    for (int r = first; r <= last; r++) run_round(r, dly, salt);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 20) begin
      tick();
      n++;
    end
    chk("done_seen", 128'(bus.done), 128'(1));
  endtask

  task automatic check_idle(string tag, int exp_done);
    tick();
    chk({tag, "_busy"}, 128'(bus.busy), 128'(0));
    chk({tag, "_done_low"}, 128'(bus.done), 128'(0));
    chk({tag, "_done_cnt"}, 128'(done_cnt), 128'(exp_done));
    chk({tag, "_sb_empty"}, 128'(sbq.size()), 128'(0));
  endtask

  initial begin
    int d0;
    int s0;
    int n;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.key_rdy   = 1'b0;
    bus.round_key = '0;
    bus.rk_ready  = 1'b0;
    reset         = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_encrypt_en", 128'(bus.encrypt_en), 128'(0));
    chk("rst_key_sel", 128'(bus.key_sel), 128'(0));
    chk("rst_rk_valid", 128'(bus.rk_valid), 128'(0));
    chk("rst_rk_data", bus.rk_data, 128'(0));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_timeout_err", 128'(bus.timeout_err), 128'(0));
    reset = 1'b0;
    tick();

    // Nominal: key_rdy 3 cycles after each key_sel change, rk_ready tied 1
    bus.rk_ready = 1'b1;
    d0 = done_cnt;
    start_seq();
    chk("nom_key_sel0", 128'(bus.key_sel), 128'(0));
    chk("nom_encrypt_en", 128'(bus.encrypt_en), 128'(1));
    run_seq(0, NR, 3, 8'h00);
    wait_done();
    chk("nom_encrypt_en_done", 128'(bus.encrypt_en), 128'(0));
    check_idle("nom", d0 + 1);

    // Minimum latency with key_rdy and rk_ready immediately available
    d0 = done_cnt;
    start_seq();
    s0 = cyc;
    run_seq(0, NR, 0, 8'h3C);
    wait_done();
    check_idle("lat", d0 + 1);
    chk("lat_cycles", 128'(done_at - s0 + 1), 128'(1 + 2 * (NR + 1)));

    // Back-pressure in round 4, plus ignored start/key_rdy
    d0 = done_cnt;
    start_seq();
    run_seq(0, 3, 1, 8'h5A);
    wait_req(4);
    bus.start = 1'b1;                 // ignored in REQ
    tick();
    bus.start = 1'b0;
    chk("bp_start_ign_sel", 128'(bus.key_sel), 128'(4));
    bus.rk_ready = 1'b0;
    give_key(4, 8'h5A);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 128'(bus.rk_valid), 128'(1));
      chk("bp_key_sel", 128'(bus.key_sel), 128'(4));
      if (i == 1) begin               // ignored in PRESENT
        bus.start     = 1'b1;
        bus.key_rdy   = 1'b1;
        bus.round_key = key_of(4, 8'hFF);
      end
      tick();
      bus.start   = 1'b0;
      bus.key_rdy = 1'b0;
    end
    chk("bp_rk_round", 128'(bus.rk_round), 128'(4));
    chk("bp_rk_data", bus.rk_data, key_of(4, 8'h5A));
    bus.rk_ready = 1'b1;
    run_seq(5, NR, 2, 8'h5A);
    wait_done();
    check_idle("bp", d0 + 1);

    // Timeout in round 2
    d0 = done_cnt;
    start_seq();
    run_seq(0, 1, 1, 8'hC3);
    wait_req(2);
    n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    chk("to_cycles", 128'(n), 128'(TO));
    chk("to_err", 128'(bus.timeout_err), 128'(1));
    check_idle("to", d0);
    chk("to_err_sticky", 128'(bus.timeout_err), 128'(1));
    start_seq();
    chk("to_restart_err_clr", 128'(bus.timeout_err), 128'(0));
    chk("to_restart_sel", 128'(bus.key_sel), 128'(0));
    chk("to_restart_en", 128'(bus.encrypt_en), 128'(1));
    bus.abort = 1'b1;                 // abort from REQ
    tick();
    bus.abort = 1'b0;
    chk("ab_req_busy", 128'(bus.busy), 128'(0));

    // Abort in PRESENT of round 6
    d0 = done_cnt;
    start_seq();
    run_seq(0, 5, 1, 8'h96);
    wait_req(6);
    bus.rk_ready = 1'b0;
    give_key(6, 8'h96);
    chk("ab_valid_before", 128'(bus.rk_valid), 128'(1));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    sbq.delete();
    chk("ab_rk_valid", 128'(bus.rk_valid), 128'(0));
    chk("ab_encrypt_en", 128'(bus.encrypt_en), 128'(0));
    chk("ab_busy", 128'(bus.busy), 128'(0));
    chk("ab_rk_data_held", bus.rk_data, key_of(6, 8'h96));
    bus.start = 1'b1;                 // start with abort in IDLE: ignored
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("ab_start_ign_busy", 128'(bus.busy), 128'(0));
    chk("ab_start_ign_en", 128'(bus.encrypt_en), 128'(0));
    check_idle("ab", d0);
    bus.rk_ready = 1'b1;

    // Asynchronous reset mid-cycle during round 3
    start_seq();
    run_seq(0, 2, 1, 8'h11);
    wait_req(3);
    tick();
    #1;
    reset = 1'b1;
    #1;
    chk("ar_encrypt_en", 128'(bus.encrypt_en), 128'(0));
    chk("ar_key_sel", 128'(bus.key_sel), 128'(0));
    chk("ar_rk_valid", 128'(bus.rk_valid), 128'(0));
    chk("ar_rk_data", bus.rk_data, 128'(0));
    chk("ar_rk_round", 128'(bus.rk_round), 128'(0));
    chk("ar_rk_last", 128'(bus.rk_last), 128'(0));
    chk("ar_busy", 128'(bus.busy), 128'(0));
    chk("ar_done", 128'(bus.done), 128'(0));
    chk("ar_timeout_err", 128'(bus.timeout_err), 128'(0));
    sbq.delete();
    tick();
    reset = 1'b0;
    tick();
    d0 = done_cnt;
    start_seq();
    chk("ar_restart_sel", 128'(bus.key_sel), 128'(0));
    run_seq(0, NR, 1, 8'h77);
    wait_done();
    check_idle("ar", d0 + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
